hxm_event_sequencer: RTL and testbench
======================================

Name: hxm_event_sequencer

Overview:
Controller that sequences the hxmpp hit memory through one event at a time: clear, then write phase, then read phase, then drain.
- Accepts a hit stream (SSID + hit info) and a road-readout request stream (SSID), each with valid/ready handshakes.
- Drives the hxmpp reset/write/read strobes, and throttles reads so at most MAX_OUTSTANDING are in flight.
- Sits between the upstream hit/road FIFOs and the hxmpp instance.

Parameters:
SSID_W, 12, width of SSID on all SSID ports
HITINFO_W, 16, width of hit info word
CLEAR_CYCLES, 4, cycles hxm_reset is held high per event clear (min 1)
MAX_OUTSTANDING, 4, max issued reads without readFinished (power of 2 not required, >=1)
CNT_W, 16, width of event_id and hit_count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hit_valid  in  1  hit word valid
hit_ready  out  1  sequencer accepts hit this cycle
hit_ssid  in  SSID_W  SSID of hit
hit_info  in  HITINFO_W  hit info of hit
hit_last  in  1  qualifies last hit of event (with hit_valid)
req_valid  in  1  read request valid
req_ready  out  1  sequencer accepts request this cycle
req_ssid  in  SSID_W  SSID to read
req_last  in  1  qualifies last request of event
hxm_reset  out  1  to hxmpp reset
hxm_write  out  1  to hxmpp write
hxm_write_ssid  out  SSID_W  to hxmpp writeSSID
hxm_write_hitinfo  out  HITINFO_W  to hxmpp writeHitInfo
hxm_read  out  1  to hxmpp read
hxm_read_ssid  out  SSID_W  to hxmpp readSSID
hxm_read_finished  in  1  from hxmpp readFinished (one pulse per completed read)
event_done  out  1  one-cycle pulse when event fully drained
event_id  out  CNT_W  count of completed events, wraps
hit_count  out  CNT_W  hits written in current event, saturates at all-ones
outstanding  out  clog2(MAX_OUTSTANDING+1)  reads in flight
err_underflow  out  1  sticky: hxm_read_finished with outstanding==0

Behaviour:
- All outputs registered. On reset:
  - state=CLEAR, clear counter=0, hxm_reset=1.
  - hxm_write=hxm_read=0; SSID/info outputs=0.
  - hit_ready=req_ready=0, event_done=0, event_id=0, hit_count=0, outstanding=0, err_underflow=0.
- Reset asserted mid-operation aborts the event; any in-flight read completions after reset are counted as underflow only if they arrive once outstanding==0 (i.e. they do set err_underflow).
- States:
  - CLEAR: hxm_reset=1 for exactly CLEAR_CYCLES cycles, then hit_count<=0 -> WRITE.
  - WRITE: hit_ready=1. On hit_valid&hit_ready:
    - next cycle hxm_write=1, with hxm_write_ssid/hitinfo = captured values; hit_count+1 (saturating).
    - If hit_last, -> READ.
    - One-cycle latency, back-to-back accepts allowed (one write per cycle).
    - An event with zero hits is encoded as hit_valid&hit_last; that word is still written.
  - READ: req_ready = (outstanding < MAX_OUTSTANDING). On req_valid&req_ready:
    - next cycle hxm_read=1, hxm_read_ssid=req_ssid.
    - If req_last, -> DRAIN.
  - DRAIN: req_ready=0; when outstanding==0 (after update) -> DONE.
  - DONE: event_done=1 for one cycle, event_id+1 (wraps modulo 2^CNT_W) -> CLEAR.
- hit_ready=0 outside WRITE; req_ready=0 outside READ. Inputs presented with ready=0 are ignored, not lost (source holds).
- outstanding update per cycle: +1 on request accept, -1 on hxm_read_finished.
  - Both in the same cycle: unchanged.
  - finished with outstanding==0 and no accept: stays 0, err_underflow<=1 (cleared only by reset).
- req_ready uses the registered outstanding value: no combinational path from hxm_read_finished to req_ready.
- hxm_write and hxm_read are never high in the same cycle; hxm_reset never overlaps either.

Test Plan:
- Reset with CLEAR_CYCLES=4 -> hxm_reset high exactly 4 cycles after reset deasserts; hit_ready rises the following cycle; all other outputs 0.
- 23 back-to-back hits, SSIDs 0x808..0x406, last flagged -> 23 consecutive hxm_write pulses one cycle after each accept; hit_count=23; state to READ.
- 10 read requests with hxm_read_finished held 0, MAX_OUTSTANDING=4 -> exactly 4 hxm_read pulses, req_ready low, outstanding=4. Then one finished pulse -> one more read issued next cycle.
- Same-cycle accept and finished -> outstanding unchanged. Final finished after req_last -> event_done pulse once, event_id 0->1, re-enters CLEAR.
- hxm_read_finished while idle in WRITE -> err_underflow=1 and stays set through the next event until reset.
- Reset asserted during READ with 3 outstanding -> next cycle outstanding=0, state CLEAR, hxm_read=0, event_id=0.

Source files
------------

// File: rtl/hxm_event_sequencer.sv
// -----------------------------------------------------------------------------
// hxm_event_sequencer
//
// Sequences the hxmpp hit memory through one event at a time:
//   CLEAR -> WRITE -> READ -> DRAIN -> DONE -> CLEAR ...
//
// CLEAR : hxm_reset is held high for CLEAR_CYCLES cycles, then hit_count is
//         zeroed and the hit stream is opened.
// WRITE : every accepted hit is written to hxmpp on the following cycle. The
//         word carrying hit_last is written too, then the sequencer moves to
//         READ. An empty event is a single hit_valid & hit_last word.
// READ  : every accepted request issues an hxmpp read on the following cycle.
//         At most MAX_OUTSTANDING reads may be waiting for readFinished. The
//         request carrying req_last moves the sequencer to DRAIN.
// DRAIN : no new requests. Waits until every issued read has completed.
// DONE  : one-cycle event_done pulse, event_id increments, back to CLEAR.
//
// Handshakes: a word moves when valid and ready are both high on a rising
// clock edge. ready is a registered output that never depends on valid in the
// same cycle. When ready is low the source holds its word; nothing is dropped.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   hit_valid/ready       hit stream handshake
//   hit_ssid/info/last    hit payload; hit_last marks the final hit of event
//   req_valid/ready       road-readout request handshake
//   req_ssid/last         request payload; req_last marks the final request
//   hxm_reset             hxmpp reset strobe
//   hxm_write(+ssid/info) hxmpp write strobe and write data
//   hxm_read(+ssid)       hxmpp read strobe and read SSID
//   hxm_read_finished     hxmpp readFinished, one pulse per completed read
//   event_done            one-cycle pulse when an event is fully drained
//   event_id              completed-event counter, wraps
//   hit_count             hits written in the current event, saturates
//   outstanding           reads issued and not yet finished
//   err_underflow         sticky: readFinished seen with nothing in flight
//   dbg_state             current sequencer state (CLEAR=0, WRITE=1, READ=2,
//                         DRAIN=3, DONE=4)
//
// All outputs are registers.
// -----------------------------------------------------------------------------
module hxm_event_sequencer #(
  parameter int SSID_W          = 12,
  parameter int HITINFO_W       = 16,
  parameter int CLEAR_CYCLES    = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 hit_valid,
  output logic                 hit_ready,
  input  logic [SSID_W-1:0]    hit_ssid,
  input  logic [HITINFO_W-1:0] hit_info,
  input  logic                 hit_last,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SSID_W-1:0]    req_ssid,
  input  logic                 req_last,

  output logic                 hxm_reset,
  output logic                 hxm_write,
  output logic [SSID_W-1:0]    hxm_write_ssid,
  output logic [HITINFO_W-1:0] hxm_write_hitinfo,
  output logic                 hxm_read,
  output logic [SSID_W-1:0]    hxm_read_ssid,
  input  logic                 hxm_read_finished,

  output logic                 event_done,
  output logic [CNT_W-1:0]     event_id,
  output logic [CNT_W-1:0]     hit_count,
  output logic [OUT_W-1:0]     outstanding,
  output logic                 err_underflow,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // clear_cnt runs 0 .. CLEAR_CYCLES-1 while hxm_reset is high.
  localparam int               CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t               state;
  state_t               state_d;
  logic [CLR_W-1:0]     clear_cnt;
  logic [CLR_W-1:0]     clear_cnt_d;

  logic                 hit_acc;
  logic                 req_acc;

  logic                 hit_ready_d;
  logic                 req_ready_d;
  logic                 hxm_reset_d;
  logic                 hxm_write_d;
  logic [SSID_W-1:0]    hxm_write_ssid_d;
  logic [HITINFO_W-1:0] hxm_write_hitinfo_d;
  logic                 hxm_read_d;
  logic [SSID_W-1:0]    hxm_read_ssid_d;
  logic                 event_done_d;
  logic [CNT_W-1:0]     event_id_d;
  logic [CNT_W-1:0]     hit_count_d;
  logic [OUT_W-1:0]     outstanding_d;
  logic                 err_underflow_d;

  assign dbg_state = state;

  // ready outputs are registers, so an accept is decided purely from state
  // captured on the previous edge.
  assign hit_acc = hit_valid & hit_ready;
  assign req_acc = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d             = state;
    clear_cnt_d         = clear_cnt;
    outstanding_d       = outstanding;
    err_underflow_d     = err_underflow;
    hit_count_d         = hit_count;
    event_id_d          = event_id;
    hxm_write_d         = hit_acc;
    hxm_write_ssid_d    = hxm_write_ssid;
    hxm_write_hitinfo_d = hxm_write_hitinfo;
    hxm_read_d          = req_acc;
    hxm_read_ssid_d     = hxm_read_ssid;

    // Read-in-flight accounting. An accept and a completion in the same cycle
    // cancel. A completion with nothing in flight is flagged, never wrapped.
    if (req_acc && !hxm_read_finished) begin
      outstanding_d = outstanding + OUT_W'(1);
    end else if (!req_acc && hxm_read_finished) begin
      if (outstanding == '0) begin
        err_underflow_d = 1'b1;
      end else begin
        outstanding_d = outstanding - OUT_W'(1);
      end
    end

    if (hit_acc) begin
      hxm_write_ssid_d    = hit_ssid;
      hxm_write_hitinfo_d = hit_info;
      if (hit_count != CNT_SAT) begin
        hit_count_d = hit_count + CNT_W'(1);
      end
    end

    if (req_acc) begin
      hxm_read_ssid_d = req_ssid;
    end

    case (state)
      ST_CLEAR: begin
        if (clear_cnt == CLR_LAST) begin
          state_d     = ST_WRITE;
          hit_count_d = '0;
        end else begin
          clear_cnt_d = clear_cnt + CLR_W'(1);
        end
      end
      ST_WRITE: begin
        if (hit_acc && hit_last) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (req_acc && req_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Judged on the updated count so a completion arriving this cycle
        // can end the event without an extra idle cycle.
        if (outstanding_d == '0) begin
          state_d    = ST_DONE;
          event_id_d = event_id + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d     = ST_CLEAR;
        clear_cnt_d = '0;
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_cnt_d = '0;
      end
    endcase

    // Registered strobes/readies follow the state being entered.
    hxm_reset_d  = (state_d == ST_CLEAR);
    hit_ready_d  = (state_d == ST_WRITE);
    req_ready_d  = (state_d == ST_READ) && (outstanding_d < OUT_MAX);
    event_done_d = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_CLEAR;
      clear_cnt         <= '0;
      hxm_reset         <= 1'b1;
      hit_ready         <= 1'b0;
      req_ready         <= 1'b0;
      hxm_write         <= 1'b0;
      hxm_write_ssid    <= '0;
      hxm_write_hitinfo <= '0;
      hxm_read          <= 1'b0;
      hxm_read_ssid     <= '0;
      event_done        <= 1'b0;
      event_id          <= '0;
      hit_count         <= '0;
      outstanding       <= '0;
      err_underflow     <= 1'b0;
    end else begin
      state             <= state_d;
      clear_cnt         <= clear_cnt_d;
      hxm_reset         <= hxm_reset_d;
      hit_ready         <= hit_ready_d;
      req_ready         <= req_ready_d;
      hxm_write         <= hxm_write_d;
      hxm_write_ssid    <= hxm_write_ssid_d;
      hxm_write_hitinfo <= hxm_write_hitinfo_d;
      hxm_read          <= hxm_read_d;
      hxm_read_ssid     <= hxm_read_ssid_d;
      event_done        <= event_done_d;
      event_id          <= event_id_d;
      hit_count         <= hit_count_d;
      outstanding       <= outstanding_d;
      err_underflow     <= err_underflow_d;
    end
  end

endmodule

// File: tb/tb_hxm_event_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hxm_event_sequencer
//
// Inputs are driven on the falling clock edge; DUT outputs are sampled 2 time
// units after the rising edge. Drivers push expected hxmpp writes/reads (with
// the cycle they are due) into queues; a monitor pops and compares.
// A small reference model tracks reads in flight, the underflow flag, event
// completion and the event counter from the handshakes the bench drives.
// -----------------------------------------------------------------------------
module tb_hxm_event_sequencer;

  localparam int SSID_W          = 12;
  localparam int HITINFO_W       = 16;
  localparam int CLEAR_CYCLES    = 4;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CNT_W           = 16;
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1);
  localparam int WR_W            = SSID_W + HITINFO_W;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 hit_valid = 1'b0;
  logic                 hit_ready;
  logic [SSID_W-1:0]    hit_ssid = '0;
  logic [HITINFO_W-1:0] hit_info = '0;
  logic                 hit_last = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [SSID_W-1:0]    req_ssid = '0;
  logic                 req_last = 1'b0;
  logic                 hxm_reset;
  logic                 hxm_write;
  logic [SSID_W-1:0]    hxm_write_ssid;
  logic [HITINFO_W-1:0] hxm_write_hitinfo;
  logic                 hxm_read;
  logic [SSID_W-1:0]    hxm_read_ssid;
  logic                 hxm_read_finished = 1'b0;
  logic                 event_done;
  logic [CNT_W-1:0]     event_id;
  logic [CNT_W-1:0]     hit_count;
  logic [OUT_W-1:0]     outstanding;
  logic                 err_underflow;
  logic [2:0]           dbg_state;

  hxm_event_sequencer #(
    .SSID_W(SSID_W), .HITINFO_W(HITINFO_W), .CLEAR_CYCLES(CLEAR_CYCLES),
    .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ssid(hit_ssid),
    .hit_info(hit_info), .hit_last(hit_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_ssid(req_ssid),
    .req_last(req_last),
    .hxm_reset(hxm_reset), .hxm_write(hxm_write),
    .hxm_write_ssid(hxm_write_ssid), .hxm_write_hitinfo(hxm_write_hitinfo),
    .hxm_read(hxm_read), .hxm_read_ssid(hxm_read_ssid),
    .hxm_read_finished(hxm_read_finished),
    .event_done(event_done), .event_id(event_id), .hit_count(hit_count),
    .outstanding(outstanding), .err_underflow(err_underflow),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WR_W-1:0]   wr_q[$];
  int                wr_due_q[$];
  logic [SSID_W-1:0] rd_q[$];
  int                rd_due_q[$];

  int wr_seen = 0;
  int rd_seen = 0;
  int done_seen = 0;
  bit mon_en = 1'b0;
  bit drv_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, advanced on every rising edge from the driven handshakes
  // ---------------------------------------------------------------------------
  int               cyc = 0;
  int               out_m = 0;
  bit               err_m = 1'b0;
  bit               drain_m = 1'b0;
  logic [CNT_W-1:0] ev_m = '0;
  int               done_due = -1;

  function automatic int next_out(input int o, input bit acc, input bit fin);
    if (acc && !fin) return o + 1;
    if (fin && !acc && o > 0) return o - 1;
    return o;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      out_m   <= 0;
      err_m   <= 1'b0;
      drain_m <= 1'b0;
      ev_m    <= '0;
    end else begin
      out_m <= next_out(out_m, req_valid && req_ready, hxm_read_finished);
      if (hxm_read_finished && !(req_valid && req_ready) && out_m == 0)
        err_m <= 1'b1;
      if (req_valid && req_ready && req_last) begin
        drain_m <= 1'b1;
      end else if (drain_m && next_out(out_m, 1'b0, hxm_read_finished) == 0) begin
        drain_m  <= 1'b0;
        ev_m     <= ev_m + CNT_W'(1);
        done_due <= cyc + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (hxm_write) begin
          wr_seen++;
          if (wr_q.size() == 0) begin
            check("write_unexpected", 64'(hxm_write), 64'(0));
          end else begin
            check("write_data", 64'({hxm_write_ssid, hxm_write_hitinfo}), 64'(wr_q.pop_front()));
            check("write_latency", 64'(cyc), 64'(wr_due_q.pop_front()));
          end
        end else if (wr_due_q.size() != 0 && wr_due_q[0] <= cyc) begin
          check("write_missing", 64'(hxm_write), 64'(1));
          void'(wr_q.pop_front());
          void'(wr_due_q.pop_front());
        end

        if (hxm_read) begin
          rd_seen++;
          if (rd_q.size() == 0) begin
            check("read_unexpected", 64'(hxm_read), 64'(0));
          end else begin
            check("read_ssid", 64'(hxm_read_ssid), 64'(rd_q.pop_front()));
            check("read_latency", 64'(cyc), 64'(rd_due_q.pop_front()));
          end
        end else if (rd_due_q.size() != 0 && rd_due_q[0] <= cyc) begin
          check("read_missing", 64'(hxm_read), 64'(1));
          void'(rd_q.pop_front());
          void'(rd_due_q.pop_front());
        end

        if (event_done) done_seen++;
        check("outstanding", 64'(outstanding), 64'(out_m));
        check("err_underflow", 64'(err_underflow), 64'(err_m));
        check("event_id", 64'(event_id), 64'(ev_m));
        check("event_done", 64'(event_done), 64'(cyc == done_due));
        check("wr_rd_overlap", 64'(hxm_write & hxm_read), 64'(0));
        check("reset_overlap", 64'(hxm_reset & (hxm_write | hxm_read)), 64'(0));
        check("ready_overlap", 64'(hit_ready & req_ready), 64'(0));
        check("req_ready_cap", 64'(req_ready & (out_m >= MAX_OUTSTANDING)), 64'(0));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: called on a falling edge, return on a falling edge
  // ---------------------------------------------------------------------------
  task automatic send_hit(input logic [SSID_W-1:0] s, input logic [HITINFO_W-1:0] i,
                          input logic l);
    int waitc = 0;
    hit_valid = 1'b1;
    hit_ssid  = s;
    hit_info  = i;
    hit_last  = l;
    while (!hit_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("hit_accept_wait", 64'(hit_ready), 64'(1));
    if (hit_ready) begin
      wr_q.push_back({s, i});
      wr_due_q.push_back(cyc + 1);
    end
    @(negedge clk);
    hit_valid = 1'b0;
    hit_last  = 1'b0;
  endtask

  task automatic send_req(input logic [SSID_W-1:0] s, input logic l, input bit with_fin);
    int waitc = 0;
    req_valid = 1'b1;
    req_ssid  = s;
    req_last  = l;
    while (!req_ready && waitc < 500) begin
      @(negedge clk);
      waitc++;
    end
    check("req_accept_wait", 64'(req_ready), 64'(1));
    if (req_ready) begin
      rd_q.push_back(s);
      rd_due_q.push_back(cyc + 1);
      if (with_fin) hxm_read_finished = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_last  = 1'b0;
    if (with_fin) hxm_read_finished = 1'b0;
  endtask

  task automatic pulse_fin();
    hxm_read_finished = 1'b1;
    @(negedge clk);
    hxm_read_finished = 1'b0;
  endtask

  task automatic wait_hit_ready();
    int waitc = 0;
    while (!hit_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("hit_ready_wait", 64'(hit_ready), 64'(1));
  endtask

  task automatic drain_all();
    int n = 0;
    while (out_m > 0 && n < 500) begin
      hxm_read_finished = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n++;
    end
    hxm_read_finished = 1'b0;
    check("drain_outstanding", 64'(outstanding), 64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int nh;
    int nr;
    logic [SSID_W-1:0] s;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    // Reset values
    check("rst_hxm_reset", 64'(hxm_reset), 64'(1));
    check("rst_hit_ready", 64'(hit_ready), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_write", 64'(hxm_write), 64'(0));
    check("rst_read", 64'(hxm_read), 64'(0));
    check("rst_write_data", 64'({hxm_write_ssid, hxm_write_hitinfo}), 64'(0));
    check("rst_read_ssid", 64'(hxm_read_ssid), 64'(0));
    check("rst_hit_count", 64'(hit_count), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    // Clear phase length after reset release
    reset = 1'b0;
    n = 0;
    while (hxm_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", 64'(n), 64'(CLEAR_CYCLES));
    check("hit_ready_after_clear", 64'(hit_ready), 64'(1));

    // Event 1: 23 back-to-back hits, SSIDs stepping 0x808 down to 0x406
    for (int i = 0; i < 23; i++) begin
      s = 12'(32'h808 - (i * 32'h402) / 22);
      send_hit(s, 16'($urandom), (i == 22));
    end
    check("ev1_hit_count", 64'(hit_count), 64'(23));
    check("ev1_writes", 64'(wr_seen), 64'(23));
    check("ev1_hit_ready_low", 64'(hit_ready), 64'(0));
    check("ev1_req_ready", 64'(req_ready), 64'(1));

    // 10 requests with no completions: capped at MAX_OUTSTANDING
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_req(12'($urandom), (i == 9), 1'b0);
        drv_done = 1'b1;
      end
    join_none
    repeat (20) @(negedge clk);
    check("cap_reads", 64'(rd_seen), 64'(MAX_OUTSTANDING));
    check("cap_req_ready", 64'(req_ready), 64'(0));
    check("cap_outstanding", 64'(outstanding), 64'(MAX_OUTSTANDING));
    pulse_fin();
    repeat (2) @(negedge clk);
    check("one_more_read", 64'(rd_seen), 64'(MAX_OUTSTANDING + 1));

    n = 0;
    while ((!drv_done || out_m > 0) && n < 2000) begin
      hxm_read_finished = (out_m > 0) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n++;
    end
    hxm_read_finished = 1'b0;
    check("ev1_drained", 64'(outstanding), 64'(0));
    repeat (2) @(negedge clk);
    check("ev1_done_count", 64'(done_seen), 64'(1));
    check("ev1_event_id", 64'(event_id), 64'(1));
    check("ev1_reclear", 64'(hxm_reset), 64'(1));

    // Event 2: underflow while idle in WRITE, then random traffic
    wait_hit_ready();
    check("ev2_hit_count_zero", 64'(hit_count), 64'(0));
    pulse_fin();
    check("ev2_underflow_set", 64'(err_underflow), 64'(1));
    nh = $urandom_range(1, 12);
    for (int i = 0; i < nh; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_hit(12'($urandom), 16'($urandom), (i == nh - 1));
    end
    check("ev2_hit_count", 64'(hit_count), 64'(nh));
    nr = $urandom_range(2, 8);
    for (int i = 0; i < nr; i++) begin
      if (out_m >= MAX_OUTSTANDING) pulse_fin();
      else if (out_m > 0 && $urandom_range(0, 2) == 0) pulse_fin();
      send_req(12'($urandom), (i == nr - 1), (out_m > 0) && (i % 2 == 1));
    end
    drain_all();
    repeat (2) @(negedge clk);
    check("ev2_done_count", 64'(done_seen), 64'(2));
    check("ev2_event_id", 64'(event_id), 64'(2));
    check("ev2_underflow_sticky", 64'(err_underflow), 64'(1));

    // Event 3: empty event (single last word), 3 reads in flight, then reset
    wait_hit_ready();
    send_hit(12'($urandom), 16'($urandom), 1'b1);
    check("ev3_hit_count", 64'(hit_count), 64'(1));
    for (int i = 0; i < 3; i++) send_req(12'($urandom), 1'b0, 1'b0);
    check("ev3_outstanding", 64'(outstanding), 64'(3));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outstanding", 64'(outstanding), 64'(0));
    check("mid_rst_read", 64'(hxm_read), 64'(0));
    check("mid_rst_clear", 64'(hxm_reset), 64'(1));
    check("mid_rst_event_id", 64'(event_id), 64'(0));
    check("mid_rst_underflow", 64'(err_underflow), 64'(0));
    reset = 1'b0;
    pulse_fin();
    check("late_fin_underflow", 64'(err_underflow), 64'(1));
    wait_hit_ready();
    repeat (2) @(negedge clk);

    check("wr_q_empty", 64'(wr_q.size()), 64'(0));
    check("rd_q_empty", 64'(rd_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
